serial_frame_receiver: RTL and testbench

- Receive side of the team's serial shift-register link.
- Takes the framed bit stream produced by a shift-register transmitter: one start bit (0), WIDTH data bits, one stop bit (1).
- Reassembles each frame into a parallel word and presents it on a valid/ready interface.
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/serial_frame_receiver_if.sv | 36 +++
 rtl/serial_frame_receiver.sv | 123 ++++++++++++
 tb/tb_serial_frame_receiver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_frame_receiver_if.sv
// Bundle of the serial-in / parallel-out signals of the frame receiver.
// The slave modport is the receiver; the master modport is the line driver and word consumer.
interface serial_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic             bit_valid;
    logic             word_ready;
    logic [WIDTH-1:0] block;
    logic             word_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        output serial_in,
        output bit_valid,
        output word_ready,
        input  block,
        input  word_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

    modport slave (
        input  serial_in,
        input  bit_valid,
        input  word_ready,
        output block,
        output word_valid,
        output frame_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Receives start/data/stop framed serial bits and presents each good word on a
// valid/ready holding register, pulsing frame_err or overrun when a frame is lost.
module serial_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    serial_frame_receiver_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] block_q, block_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shifted;
    logic             transfer;

    // Shift network: right-shift puts the first bit at [0], left-shift at [WIDTH-1].
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST) begin : g_left
            if (gi == 0) begin : g_in
                assign shifted[gi] = bus.serial_in;
            end else begin : g_mv
                assign shifted[gi] = shift_q[gi-1];
            end
        end else begin : g_right
            if (gi == WIDTH - 1) begin : g_in
                assign shifted[gi] = bus.serial_in;
            end else begin : g_mv
                assign shifted[gi] = shift_q[gi+1];
            end
        end
    end

    assign transfer = valid_q & bus.word_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            block_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            block_q <= block_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        block_d = block_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (transfer) begin
            valid_d = 1'b0;
        end

        if (bus.bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (bus.serial_in) begin
                        // A word consumed on this same edge frees the register for the new one.
                        if (!valid_q || transfer) begin
                            block_d = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.block      = block_q;
    assign bus.word_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: an LSB-first and an MSB-first instance
// receive the same stimulus and are checked against hand-computed words.
module tb_serial_frame_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_frame_receiver_if #(.WIDTH(4)) if_l ();
    serial_frame_receiver_if #(.WIDTH(4)) if_m ();

    assign if_m.serial_in  = if_l.serial_in;
    assign if_m.bit_valid  = if_l.bit_valid;
    assign if_m.word_ready = if_l.word_ready;

    serial_frame_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (if_l.slave)
    );

    serial_frame_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (if_m.slave)
    );

    // Present one valid bit, consumed on the next rising edge; returns 1 time unit after it.
    task automatic send_bit(input logic b);
        @(negedge clk);
        if_l.serial_in = b;
        if_l.bit_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle with bit_valid low; the line is toggled to prove it is ignored.
    task automatic gap();
        @(negedge clk);
        if_l.bit_valid = 1'b0;
        if_l.serial_in = ~if_l.serial_in;
        @(posedge clk);
        #1;
    endtask

    // Start bit, data LSB first, stop bit.
    task automatic send_frame(input logic [3:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        send_bit(1'b1);
        $display("frame data=%h sent: valid=%0b block=%h ovr=%0b", d, if_l.word_valid, if_l.block, if_l.overrun);
    endtask

    task automatic drain();
        @(negedge clk);
        if_l.bit_valid  = 1'b0;
        if_l.serial_in  = 1'b1;
        if_l.word_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (if_l.word_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b exp 0", if_l.word_valid); end
        if_l.word_ready = 1'b0;
    endtask

    task automatic test_reset();
        if_l.serial_in = 1'b1; if_l.bit_valid = 1'b0; if_l.word_ready = 1'b0;
        #2;
        checks++; if (if_l.block !== 4'h0 || if_l.word_valid !== 1'b0 || if_l.busy !== 1'b0) begin errors++; $display("FAIL reset_init got blk=%h v=%0b busy=%0b exp 0/0/0", if_l.block, if_l.word_valid, if_l.busy); end
        @(negedge clk); rst_n = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if_l.busy !== 1'b0) begin errors++; $display("FAIL reset_midframe_busy got %0b exp 0", if_l.busy); end
        @(negedge clk); rst_n = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        checks++; if (if_l.busy !== 1'b1 || if_l.word_valid !== 1'b0) begin errors++; $display("FAIL reset_pre_stop got busy=%0b v=%0b exp 1/0", if_l.busy, if_l.word_valid); end
        send_bit(1'b1);
        $display("frame 0,1,1,0,0,1: valid=%0b block=%h msb_block=%h", if_l.word_valid, if_l.block, if_m.block);
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'b0011) begin errors++; $display("FAIL reset_word got v=%0b blk=%b exp 1/0011", if_l.word_valid, if_l.block); end
        checks++; if (if_m.block !== 4'b1100) begin errors++; $display("FAIL reset_word_msb got %b exp 1100", if_m.block); end
        checks++; if (if_l.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after got %0b exp 0", if_l.busy); end
        drain();
    endtask

    task automatic test_gapped();
        logic [5:0] bits;
        bits = 6'b111010; // sent from bit 0 upward: 0,1,0,1,1,1
        for (int i = 0; i < 6; i++) begin
            send_bit(bits[i]);
            if (i < 5) begin
                gap();
                checks++; if (if_l.busy !== 1'b1 || if_l.word_valid !== 1'b0) begin errors++; $display("FAIL gap_hold_%0d got busy=%0b v=%0b exp 1/0", i, if_l.busy, if_l.word_valid); end
            end
        end
        $display("gapped frame: valid=%0b block=%h msb_block=%h", if_l.word_valid, if_l.block, if_m.block);
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'b1101) begin errors++; $display("FAIL gap_word got v=%0b blk=%b exp 1/1101", if_l.word_valid, if_l.block); end
        checks++; if (if_m.block !== 4'b1011) begin errors++; $display("FAIL gap_word_msb got %b exp 1011", if_m.block); end
        gap(); gap();
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'b1101 || if_l.busy !== 1'b0) begin errors++; $display("FAIL gap_word_hold got v=%0b blk=%b busy=%0b exp 1/1101/0", if_l.word_valid, if_l.block, if_l.busy); end
        drain();
    endtask

    task automatic test_frame_err();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0);
        $display("bad frame: ferr=%0b valid=%0b busy=%0b", if_l.frame_err, if_l.word_valid, if_l.busy);
        checks++; if (if_l.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %0b exp 1", if_l.frame_err); end
        checks++; if (if_l.word_valid !== 1'b0 || if_l.busy !== 1'b0 || if_l.overrun !== 1'b0) begin errors++; $display("FAIL ferr_state got v=%0b busy=%0b ovr=%0b exp 0/0/0", if_l.word_valid, if_l.busy, if_l.overrun); end
        send_bit(1'b0);
        checks++; if (if_l.frame_err !== 1'b0 || if_l.busy !== 1'b1) begin errors++; $display("FAIL ferr_clear got ferr=%0b busy=%0b exp 0/1", if_l.frame_err, if_l.busy); end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1);
        $display("frame after error: valid=%0b block=%h msb_block=%h", if_l.word_valid, if_l.block, if_m.block);
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'b1000) begin errors++; $display("FAIL ferr_next_word got v=%0b blk=%b exp 1/1000", if_l.word_valid, if_l.block); end
        checks++; if (if_m.block !== 4'b0001) begin errors++; $display("FAIL ferr_next_word_msb got %b exp 0001", if_m.block); end
        drain();
    endtask

    task automatic test_overrun();
        send_frame(4'hA);
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'hA) begin errors++; $display("FAIL ovr_first got v=%0b blk=%h exp 1/a", if_l.word_valid, if_l.block); end
        send_frame(4'h5);
        checks++; if (if_l.overrun !== 1'b1 || if_l.frame_err !== 1'b0) begin errors++; $display("FAIL ovr_pulse got ovr=%0b ferr=%0b exp 1/0", if_l.overrun, if_l.frame_err); end
        checks++; if (if_l.block !== 4'hA || if_l.word_valid !== 1'b1) begin errors++; $display("FAIL ovr_keep got blk=%h v=%0b exp a/1", if_l.block, if_l.word_valid); end
        gap();
        checks++; if (if_l.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b exp 0", if_l.overrun); end
        drain();
    endtask

    task automatic test_back_to_back();
        send_frame(4'h3);
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'h3) begin errors++; $display("FAIL b2b_first got v=%0b blk=%h exp 1/3", if_l.word_valid, if_l.block); end
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        if_l.word_ready = 1'b1;
        send_bit(1'b1);
        if_l.word_ready = 1'b0;
        $display("simultaneous load/transfer: valid=%0b block=%h ovr=%0b", if_l.word_valid, if_l.block, if_l.overrun);
        checks++; if (if_l.word_valid !== 1'b1 || if_l.block !== 4'hC) begin errors++; $display("FAIL b2b_load got v=%0b blk=%h exp 1/c", if_l.word_valid, if_l.block); end
        checks++; if (if_l.overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got %0b exp 0", if_l.overrun); end
        send_bit(1'b0); send_bit(1'b1);
        checks++; if (if_l.busy !== 1'b1 || if_l.word_valid !== 1'b1) begin errors++; $display("FAIL b2b_midframe got busy=%0b v=%0b exp 1/1", if_l.busy, if_l.word_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if_l.block !== 4'h0 || if_l.word_valid !== 1'b0 || if_l.busy !== 1'b0 || if_l.frame_err !== 1'b0 || if_l.overrun !== 1'b0) begin errors++; $display("FAIL async_reset got blk=%h v=%0b busy=%0b ferr=%0b ovr=%0b exp all 0", if_l.block, if_l.word_valid, if_l.busy, if_l.frame_err, if_l.overrun); end
        checks++; if (if_m.block !== 4'h0 || if_m.word_valid !== 1'b0) begin errors++; $display("FAIL async_reset_msb got blk=%h v=%0b exp 0/0", if_m.block, if_m.word_valid); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_gapped();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
